vend_sequencer: RTL and testbench
=================================

Name: vend_sequencer

Overview:
- Central controller for the coin-operated vending datapath.
- Accumulates credit from the coin acceptor and arbitrates product selections against per-product prices.
- Sequences one shared dispense motor, then one shared 5 tk change hopper, using request/acknowledge handshakes.
- Sits between the coin/keypad front end and the dispense/hopper actuators.

Parameters:
- PRICE0, 15, price of product 0 in tk (multiple of 5)
- PRICE1, 20, price of product 1 in tk (multiple of 5)
- PRICE2, 25, price of product 2 in tk (multiple of 5)
- PRICE3, 40, price of product 3 in tk (multiple of 5)
- CREDIT_W, 8, credit register width in bits
- MAX_CREDIT, 100, credit ceiling in tk; a coin that would exceed it is rejected
- TIMEOUT_CYC, 1000, idle cycles before auto-refund (AUTO_REFUND_EN only)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- coin_valid  in  1  coin presented this cycle
- coin_code  in  2  00=5 tk, 01=10 tk, 10=20 tk, 11=invalid
- sel_valid  in  1  product selection this cycle
- sel_id  in  2  selected product 0..3
- cancel  in  1  refund request
- disp_ack  in  1  dispense motor done
- hopper_ack  in  1  hopper ejected one 5 tk coin
- disp_req  out  1  dispense request, level
- disp_id  out  2  product being dispensed
- hopper_req  out  1  eject one 5 tk coin, level
- credit  out  CREDIT_W  current credit in tk
- busy  out  1  state is not IDLE
- coin_reject  out  1  one-cycle pulse: coin returned to the customer, not credited
- insufficient  out  1  one-cycle pulse: selection refused

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, credit=0.
  - All outputs 0, disp_id=0.
  - Reset mid-DISPENSE or mid-CHANGE abandons the operation; credit is lost.
- States: IDLE, DISPENSE, CHANGE. All outputs are registered.
- IDLE, per-cycle priority is cancel > sel_valid > coin_valid; a lower-priority event in the same cycle is dropped.
  - Dropped coin: coin_reject=1.
  - Dropped selection: no pulse.
- IDLE, cancel:
  - credit>0: go to CHANGE.
  - credit==0: no effect.
- IDLE, sel_valid with credit >= PRICE[sel_id]:
  - credit <= credit - price.
  - disp_id <= sel_id.
  - Next state DISPENSE; disp_req goes high the following cycle (1-cycle latency).
- IDLE, sel_valid with credit < price: insufficient=1 for one cycle; remain in IDLE; credit unchanged.
- IDLE, coin_valid:
  - Credited when code != 11 and credit + value <= MAX_CREDIT.
  - Otherwise coin_reject=1.
- DISPENSE:
  - disp_req held at 1 and disp_id stable until disp_ack is sampled high.
  - Then disp_req=0 on the next cycle.
  - Next state CHANGE if credit>0, else IDLE.
- CHANGE:
  - hopper_req held at 1.
  - Each cycle hopper_ack=1: credit <= credit - 5.
  - Ack with credit==5: credit=0, hopper_req=0 next cycle, go to IDLE.
- Acks outside their state are ignored (disp_ack outside DISPENSE, hopper_ack outside CHANGE).
- In DISPENSE/CHANGE:
  - coin_valid produces coin_reject.
  - sel_valid and cancel are ignored.
- Arithmetic:
  - Unsigned.
  - credit never underflows, because prices are multiples of 5 and the subtraction is guarded by the compare.
- Elaboration checks: the block stops elaboration if any PRICE is not a multiple of 5, or if MAX_CREDIT >= 2^CREDIT_W.

Optional Feature:
- Macro: AUTO_REFUND_EN.
- Defined:
  - Idle counter increments in IDLE while credit>0 and no coin/sel/cancel event occurs.
  - Any such event clears the counter.
  - When the counter reaches TIMEOUT_CYC, the block enters CHANGE and refunds all credit.
  - Counter is cleared on reset and on leaving IDLE.
- Undefined: no counter; credit is held indefinitely.

Decomposition:
- Package vend_pkg:
  - state enum (IDLE/DISPENSE/CHANGE).
  - coin code constants COIN5/COIN10/COIN20/COIN_BAD.
  - coin-value function (code to tk).
  - COIN_UNIT=5.
- Sub-module vend_payout: CHANGE-state hopper handshake and credit decrement. Interface: start, load value, hopper_req/ack, done.

Test Plan:
- Reset; coin 10, coin 10, sel 0 -> disp_req=1, disp_id=0 the cycle after sel; credit=5; ack -> one hopper_req/ack -> credit=0, IDLE.
- Coin 5, sel 3 -> insufficient pulse, credit=5, no disp_req; cancel -> one hopper coin, credit=0.
- Coin 20 ×5 (credit=100), coin 5 -> coin_reject, credit=100; sel 3 -> credit=60, dispense, then 12 hopper acks -> credit=0.
- Same cycle cancel+sel_valid+coin_valid at credit=10 -> CHANGE entered, coin_reject=1, no dispense.
- coin_valid during DISPENSE -> coin_reject; disp_ack delayed 7 cycles -> disp_req held 7 cycles, disp_id stable.
- AUTO_REFUND_EN with TIMEOUT_CYC=4: coin 10, idle 4 cycles -> CHANGE, 2 hopper coins; reset asserted mid-CHANGE -> credit=0, hopper_req=0 next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared controller state type, coin codes, coin unit and coin-code to value helper
package vend_pkg;

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;

    localparam logic [1:0] COIN5    = 2'b00;
    localparam logic [1:0] COIN10   = 2'b01;
    localparam logic [1:0] COIN20   = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    localparam int COIN_UNIT = 5;

    function automatic logic [5:0] coin_value(input logic [1:0] code);
        return code == COIN5 ? 6'd5 : code == COIN10 ? 6'd10 : code == COIN20 ? 6'd20 : 6'd0;
    endfunction

endpackage

// File: rtl/vend_payout.sv
// vend_payout: hopper handshake that pays out the loaded credit one 5 tk coin per ack
// Ports: clock, reset (sync, active-high); start/load capture the amount to refund;
//        hopper_req/hopper_ack handshake; remain is the unpaid amount; done marks the last ack.
module vend_payout
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [CREDIT_W-1:0] load,
    input  logic                hopper_ack,
    output logic                hopper_req,
    output logic [CREDIT_W-1:0] remain,
    output logic                done
);

    assign done = hopper_req && hopper_ack && remain == CREDIT_W'(COIN_UNIT);

    always_ff @(posedge clock)
        if (reset) begin
            hopper_req <= 1'b0;
            remain     <= '0;
        end else if (start) begin
            hopper_req <= 1'b1;
            remain     <= load;
        end else if (hopper_req && hopper_ack) begin
            hopper_req <= !done;
            remain     <= remain - CREDIT_W'(COIN_UNIT);
        end

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: vending controller accumulating credit, arbitrating selections, sequencing dispense then change
// Ports: clock, reset (sync, active-high); coin_valid/coin_code, sel_valid/sel_id, cancel from the front end;
//        disp_req/disp_id/disp_ack to the motor; hopper_req/hopper_ack to the change hopper;
//        credit, busy, coin_reject and insufficient as registered status.
// Optional macro AUTO_REFUND_EN: refunds all credit after TIMEOUT_CYC idle cycles.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int PRICE0      = 15,
    parameter int PRICE1      = 20,
    parameter int PRICE2      = 25,
    parameter int PRICE3      = 40,
    parameter int CREDIT_W    = 8,
    parameter int MAX_CREDIT  = 100,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                sel_valid,
    input  logic [1:0]          sel_id,
    input  logic                cancel,
    input  logic                disp_ack,
    input  logic                hopper_ack,
    output logic                disp_req,
    output logic [1:0]          disp_id,
    output logic                hopper_req,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                insufficient
);

    if (PRICE0 % 5 != 0 || PRICE1 % 5 != 0 || PRICE2 % 5 != 0 || PRICE3 % 5 != 0 ||
        MAX_CREDIT >= (1 << CREDIT_W) || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $fatal(1, "vend_sequencer: prices must be multiples of 5 and MAX_CREDIT must fit CREDIT_W");
    end

    function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] id);
        return id == 2'd0 ? CREDIT_W'(PRICE0) : id == 2'd1 ? CREDIT_W'(PRICE1) :
               id == 2'd2 ? CREDIT_W'(PRICE2) : CREDIT_W'(PRICE3);
    endfunction

    state_t              state, next_state;
    logic [CREDIT_W-1:0] credit_q, next_credit, price, remain;
    logic [CREDIT_W:0]   coin_sum;
    logic [1:0]          next_disp_id;
    logic                coin_ok, next_reject, next_insufficient, start, done, timeout;

`ifdef AUTO_REFUND_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt;
    logic             idle_wait;
    assign idle_wait = state == IDLE && credit_q != '0 && !(coin_valid || sel_valid || cancel);
    assign timeout   = idle_wait && idle_cnt == CNT_W'(TIMEOUT_CYC - 1);
    always_ff @(posedge clock)
        if (reset)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_wait && !timeout ? idle_cnt + CNT_W'(1) : '0;
`else
    assign timeout = 1'b0;
`endif

    // While paying out, the payout block owns the live credit value.
    assign credit = state == CHANGE ? remain : credit_q;

    always_comb begin
        coin_sum          = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_code));
        coin_ok           = coin_code != COIN_BAD && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
        price             = price_of(sel_id);
        next_state        = state;
        next_credit       = credit_q;
        next_disp_id      = disp_id;
        next_insufficient = 1'b0;
        case (state)
            IDLE:
                if (cancel)
                    next_state = credit_q != '0 ? CHANGE : IDLE;
                else if (sel_valid && credit_q >= price) begin
                    next_credit  = credit_q - price;
                    next_disp_id = sel_id;
                    next_state   = DISPENSE;
                end else if (sel_valid)
                    next_insufficient = 1'b1;
                else if (coin_valid && coin_ok)
                    next_credit = coin_sum[CREDIT_W-1:0];
                else if (timeout)
                    next_state = CHANGE;
            DISPENSE:
                if (disp_ack)
                    next_state = credit_q != '0 ? CHANGE : IDLE;
            CHANGE: begin
                next_credit = '0;
                if (done)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        // Any coin not credited this cycle goes back to the customer.
        next_reject = coin_valid && (state != IDLE || cancel || sel_valid || !coin_ok);
        start       = state != CHANGE && next_state == CHANGE;
    end

    always_ff @(posedge clock)
        if (reset) begin
            state        <= IDLE;
            credit_q     <= '0;
            disp_id      <= '0;
            disp_req     <= 1'b0;
            busy         <= 1'b0;
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
        end else begin
            state        <= next_state;
            credit_q     <= next_credit;
            disp_id      <= next_disp_id;
            disp_req     <= next_state == DISPENSE;
            busy         <= next_state != IDLE;
            coin_reject  <= next_reject;
            insufficient <= next_insufficient;
        end

    vend_payout #(.CREDIT_W(CREDIT_W)) payout (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load       (next_credit),
        .hopper_ack (hopper_ack),
        .hopper_req (hopper_req),
        .remain     (remain),
        .done       (done)
    );

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_vend_sequencer;

`ifdef AUTO_REFUND_EN
    localparam int TO = 4;
`else
    localparam int TO = 1000;
`endif

    logic       clock = 1'b0, reset = 1'b1;
    logic       coin_valid = 1'b0, sel_valid = 1'b0, cancel = 1'b0, disp_ack = 1'b0, hopper_ack = 1'b0;
    logic [1:0] coin_code = 2'd0, sel_id = 2'd0;
    logic       disp_req, hopper_req, busy, coin_reject, insufficient;
    logic [1:0] disp_id;
    logic [7:0] credit;

    int checks = 0, errors = 0;
    bit armed = 1'b0;
    int price [4] = '{15, 20, 25, 40};
    int value [4] = '{5, 10, 20, 0};

    // phase: 0 waiting for customer, 1 motor running, 2 paying change
    typedef struct packed {int phase; int cr; int did; int rej; int ins; int cnt;} m_t;
    m_t m;

    vend_sequencer #(.TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset), .coin_valid(coin_valid), .coin_code(coin_code),
        .sel_valid(sel_valid), .sel_id(sel_id), .cancel(cancel), .disp_ack(disp_ack),
        .hopper_ack(hopper_ack), .disp_req(disp_req), .disp_id(disp_id), .hopper_req(hopper_req),
        .credit(credit), .busy(busy), .coin_reject(coin_reject), .insufficient(insufficient)
    );

    always #5 clock = ~clock;

    function automatic m_t model_next(m_t s, bit cv, int cc, bit sv, int sid, bit cn, bit da, bit ha);
        m_t n = s;
        n.rej = cv ? 1 : 0;
        n.ins = 0;
        n.cnt = 0;
        if (s.phase == 0) begin
            if (cn) begin
                if (s.cr > 0) n.phase = 2;
            end else if (sv) begin
                if (s.cr >= price[sid]) begin
                    n.cr = s.cr - price[sid];
                    n.did = sid;
                    n.phase = 1;
                end else n.ins = 1;
            end else if (cv) begin
                if (cc != 3 && s.cr + value[cc] <= 100) begin
                    n.cr = s.cr + value[cc];
                    n.rej = 0;
                end
            end
`ifdef AUTO_REFUND_EN
            else if (s.cr > 0) begin
                n.cnt = s.cnt + 1;
                if (n.cnt == TO) begin
                    n.cnt = 0;
                    n.phase = 2;
                end
            end
`endif
        end else if (s.phase == 1) begin
            if (da) n.phase = s.cr > 0 ? 2 : 0;
        end else if (ha) begin
            n.cr = s.cr - 5;
            if (n.cr == 0) n.phase = 0;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clock)
        if (reset) begin
            m <= '0;
            armed <= 1'b1;
        end else if (armed)
            m <= model_next(m, coin_valid, int'(coin_code), sel_valid, int'(sel_id), cancel, disp_ack, hopper_ack);

    always @(negedge clock)
        if (armed) begin
            chk("disp_req", int'(disp_req), int'(m.phase == 1));
            chk("hopper_req", int'(hopper_req), int'(m.phase == 2));
            chk("busy", int'(busy), int'(m.phase != 0));
            chk("credit", int'(credit), m.cr);
            chk("disp_id", int'(disp_id), m.did);
            chk("coin_reject", int'(coin_reject), m.rej);
            chk("insufficient", int'(insufficient), m.ins);
        end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic coin(input logic [1:0] c);
        coin_valid = 1'b1;
        coin_code = c;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic sel(input logic [1:0] s);
        sel_valid = 1'b1;
        sel_id = s;
        tick();
        sel_valid = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_disp_req", int'(disp_req), 0);
        chk("rst_hopper_req", int'(hopper_req), 0);
        // coin 10 + 10, buy product 0, one coin of change
        coin(2'd1);
        coin(2'd1);
        chk("s1_credit20", int'(credit), 20);
        sel(2'd0);
        chk("s1_disp_req", int'(disp_req), 1);
        chk("s1_disp_id", int'(disp_id), 0);
        chk("s1_credit5", int'(credit), 5);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("s1_disp_done", int'(disp_req), 0);
        chk("s1_hopper_req", int'(hopper_req), 1);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        chk("s1_hopper_off", int'(hopper_req), 0);
        chk("s1_credit0", int'(credit), 0);
        chk("s1_idle", int'(busy), 0);
        // insufficient then cancel
        coin(2'd0);
        sel(2'd3);
        chk("s2_insuf", int'(insufficient), 1);
        chk("s2_credit", int'(credit), 5);
        chk("s2_no_disp", int'(disp_req), 0);
        tick();
        chk("s2_insuf_pulse", int'(insufficient), 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("s2_hopper_req", int'(hopper_req), 1);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        chk("s2_credit0", int'(credit), 0);
        chk("s2_hopper_off", int'(hopper_req), 0);
        // credit ceiling, product 3, twelve change coins
        repeat (5) coin(2'd2);
        chk("s3_credit100", int'(credit), 100);
        coin(2'd0);
        chk("s3_reject", int'(coin_reject), 1);
        chk("s3_credit_held", int'(credit), 100);
        sel(2'd3);
        chk("s3_credit60", int'(credit), 60);
        chk("s3_disp_req", int'(disp_req), 1);
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("s3_hopper_req", int'(hopper_req), 1);
        chk("s3_credit60b", int'(credit), 60);
        hopper_ack = 1'b1;
        repeat (11) tick();
        chk("s3_credit5", int'(credit), 5);
        chk("s3_hopper_still", int'(hopper_req), 1);
        tick();
        hopper_ack = 1'b0;
        chk("s3_credit0", int'(credit), 0);
        chk("s3_hopper_off", int'(hopper_req), 0);
        chk("s3_idle", int'(busy), 0);
        // cancel beats selection beats coin
        coin(2'd1);
        cancel = 1'b1; sel_valid = 1'b1; sel_id = 2'd0; coin_valid = 1'b1; coin_code = 2'd0;
        tick();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0;
        chk("s4_hopper_req", int'(hopper_req), 1);
        chk("s4_reject", int'(coin_reject), 1);
        chk("s4_no_disp", int'(disp_req), 0);
        chk("s4_credit10", int'(credit), 10);
        tick();
        chk("s4_wait_credit", int'(credit), 10);
        hopper_ack = 1'b1; tick(); tick(); hopper_ack = 1'b0;
        chk("s4_credit0", int'(credit), 0);
        chk("s4_idle", int'(busy), 0);
        // exact-price buy, coin during dispense, slow motor ack
        coin(2'd2);
        sel(2'd1);
        chk("s5_credit0", int'(credit), 0);
        chk("s5_disp_req", int'(disp_req), 1);
        chk("s5_disp_id", int'(disp_id), 1);
        coin(2'd0);
        chk("s5_reject", int'(coin_reject), 1);
        chk("s5_credit_kept", int'(credit), 0);
        repeat (5) begin
            tick();
            chk("s5_disp_hold", int'(disp_req), 1);
            chk("s5_id_hold", int'(disp_id), 1);
        end
        disp_ack = 1'b1; tick(); disp_ack = 1'b0;
        chk("s5_disp_off", int'(disp_req), 0);
        chk("s5_idle", int'(busy), 0);
        chk("s5_no_change", int'(hopper_req), 0);
        // invalid coin, selection at zero credit, stray acks in IDLE
        coin(2'd3);
        chk("s6_bad_coin", int'(coin_reject), 1);
        sel(2'd0);
        chk("s6_insuf0", int'(insufficient), 1);
        coin(2'd0);
        hopper_ack = 1'b1; disp_ack = 1'b1; tick(); hopper_ack = 1'b0; disp_ack = 1'b0;
        chk("s6_stray_ack", int'(credit), 5);
        chk("s6_stray_idle", int'(busy), 0);
        cancel = 1'b1; tick(); cancel = 1'b0;
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        chk("s6_credit0", int'(credit), 0);
`ifdef AUTO_REFUND_EN
        coin(2'd1);
        repeat (3) tick();
        chk("ar_wait", int'(busy), 0);
        tick();
        chk("ar_change", int'(hopper_req), 1);
        chk("ar_credit10", int'(credit), 10);
        hopper_ack = 1'b1; tick(); hopper_ack = 1'b0;
        chk("ar_credit5", int'(credit), 5);
        reset = 1'b1; tick();
        chk("ar_rst_hopper", int'(hopper_req), 0);
        chk("ar_rst_credit", int'(credit), 0);
        reset = 1'b0;
        tick();
`endif
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
